// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative multiply/divide unit with architectural HI/LO.
// MULT/MULTU use radix-2 shift-add, and DIV/DIVU use restoring division.
// Each takes DATA_W iterations plus one sign-fix cycle.
// MTHI/MTLO write in a single cycle from IDLE.
// Optional: define MULDIV_MADD_EN to enable MADD/MADDU (op 6/7).
// These accumulate the product into {HI,LO}.
// Parameter constraints: DATA_W even and >= 8; 2**CNT_W > DATA_W.
module execute_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mf_sel,
  output logic [DATA_W-1:0] mf_result,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy,
  output logic              done,
  output logic              stall
);
  localparam int W = DATA_W;
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     hi_q, lo_q;
  logic [2*W-1:0]   prod;     // {upper accumulator, multiplier being shifted out}
  logic [W-1:0]     rem;      // partial remainder (fits W bits after each step)
  logic [W-1:0]     quo;      // dividend shifted out / quotient shifted in
  logic [W-1:0]     opnd;     // multiplicand magnitude (MUL) or divisor magnitude (DIV)
  logic [W-1:0]     a_raw;    // raw dividend, HI result on divide-by-zero
  logic             neg_res;  // negate product / quotient in FIX
  logic             neg_rem;  // negate remainder in FIX (sign of dividend)
  logic             div_zero;
  logic             fix_div;  // FIX is finishing a divide rather than a multiply
`ifdef MULDIV_MADD_EN
  logic             acc_en;   // FIX accumulates into {HI,LO}
  logic             is_madd;
`endif

  logic         is_mul, is_div, is_sgn;
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  // Decode the incoming op into path and signedness.
  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV)  || (op == OP_DIVU);
    is_sgn = (op == OP_MULT) || (op == OP_DIV);
`ifdef MULDIV_MADD_EN
    is_madd = (op == OP_MADD) || (op == OP_MADDU);
    if (is_madd)        is_mul = 1'b1;
    if (op == OP_MADD)  is_sgn = 1'b1;
`endif
  end

  assign a_neg = is_sgn & rs_data[W-1];
  assign b_neg = is_sgn & rt_data[W-1];
  assign a_mag = a_neg ? (-rs_data) : rs_data;
  assign b_mag = b_neg ? (-rt_data) : rt_data;

  // One shift-add step: add multiplicand when the low multiplier bit is set, shift right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? opnd : '0)};
  assign mul_next = {mul_sum, prod[W-1:1]};

  // One restoring step on the W+1-bit shifted remainder; a successful subtract fits back in W bits.
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] rem_next;
  assign div_shift = {rem, quo[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign rem_next  = div_ge ? (div_shift[W-1:0] - opnd) : div_shift[W-1:0];

  // Sign-corrected results applied in FIX.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res ? (-prod) : prod;
  assign quo_fix  = neg_res ? (-quo)  : quo;
  assign rem_fix  = neg_rem ? (-rem)  : rem;

  // Control FSM, iteration datapath and the HI/LO registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      fix_div  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_en   <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_mul) begin
              opnd    <= a_mag;
              prod    <= {{W{1'b0}}, b_mag};
              neg_res <= a_neg ^ b_neg;
              fix_div <= 1'b0;
`ifdef MULDIV_MADD_EN
              acc_en  <= is_madd;
`endif
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= S_MUL;
            end else if (is_div) begin
              opnd     <= b_mag;
              quo      <= a_mag;
              rem      <= '0;
              a_raw    <= rs_data;
              neg_res  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= (rt_data == '0);
              fix_div  <= 1'b1;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= S_DIV;
            end else if (op == OP_MTHI) begin
              hi_q <= rs_data;
            end else if (op == OP_MTLO) begin
              lo_q <= rs_data;
            end
          end
        end
        S_MUL: begin
          prod <= mul_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_DIV: begin
          rem <= rem_next;
          quo <= {quo[W-2:0], div_ge};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (fix_div) begin
            if (div_zero) begin
              lo_q <= '1;
              hi_q <= a_raw;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end else begin
`ifdef MULDIV_MADD_EN
            if (acc_en) {hi_q, lo_q} <= {hi_q, lo_q} + prod_fix;
            else        {hi_q, lo_q} <= prod_fix;
`else
            {hi_q, lo_q} <= prod_fix;
`endif
          end
          cnt   <= '0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign mf_result = mf_sel ? hi_q : lo_q;
  assign stall     = busy | (start & (is_mul | is_div) & busy);
endmodule
